serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Sequencer that performs WIDTH-bit addition by time-sharing one 1-bit adder cell, one bit per clock, LSB first.
//   Accepts operands on a start pulse, runs the adder for WIDTH cycles, presents sum/carry with a done pulse.
//   Sits between the lab's operand registers and the shared single-bit adder datapath; area-optimised ALU path.
// PARAMETERS
//   WIDTH   8   operand/sum width in bits (2..32)
// PORTS
//   clk     in   1      rising-edge clock, single clock domain
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      request; sampled only in IDLE or DONE
//   a       in   WIDTH  operand A, captured when start accepted
//   b       in   WIDTH  operand B, captured when start accepted
//   cin     in   1      carry-in, captured when start accepted
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse, result valid
//   sum     out  WIDTH  result, held stable from done until next accepted start
//   cout    out  1      final carry-out, held with sum
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, shift regs=0.
//   States: IDLE -> RUN -> DONE -> IDLE; encoding 2 bits, IDLE=0, RUN=1, DONE=2; 3 unreachable -> IDLE.
//   IDLE: start=1 at edge -> capture a,b into shift regs, carry reg<=cin, cnt<=0, go RUN.
//   RUN: each cycle feed a_sr[0], b_sr[0], carry reg to 1-bit adder; shift s bit into sum_sr MSB; a_sr,b_sr >> 1;
//        carry reg <= adder carry; cnt++. When cnt==WIDTH-1 (last bit) go DONE.
//   DONE: sum<=sum_sr, cout<=carry reg registered on entry; done=1 for exactly this cycle; busy=0.
//         start=1 in DONE accepted as back-to-back op (-> RUN, captures new operands); else -> IDLE.
//   Latency: start accepted at edge 0 -> done high in the cycle after edge WIDTH+1... i.e. done visible WIDTH+1 cycles after start edge.
//   start while busy: ignored, no queuing, operands not re-sampled.
//   Operand inputs may change freely after the accepting edge.
//   Width rule: internal counter $clog2(WIDTH) bits; sum is modulo 2^WIDTH, overflow beyond cout discarded.
//   Reset mid-RUN: operation abandoned, no done pulse, outputs cleared to 0.
// CONFIGURATION
//   `define SERIAL_ADD_OVF_EN : adds port  ovf  out 1  signed two's-complement overflow =
//       carry into MSB XOR carry out of MSB; reset 0; updated and held exactly like cout.
//   Without macro: port absent, no overflow logic; all other behaviour identical.
// STRUCTURE
//   Shared include serial_add_defs.vh: state localparams S_IDLE/S_RUN/S_DONE, default WIDTH.
//   One sub-module: full_adder_1b (built from two half-adder cells + OR), the shared bit-slice datapath.
//   Controller holds FSM, counter, three shift regs, output regs; no combinational path from start to outputs.
// TESTING  (WIDTH=8; cycle 0 = edge accepting start)
//   1. a=0x00,b=0x00,cin=0 -> busy cycles 1..8, done pulse once, sum=0x00,cout=0.
//   2. a=0xFF,b=0x01,cin=0 -> sum=0x00, cout=1; 0x5A+0xA5,cin=1 -> sum=0x00, cout=1.
//   3. a=0x3C,b=0x12 then start re-pulsed at cycle 3 with a=0xFF -> ignored; sum=0x4E,cout=0.
//   4. Back-to-back: start held through DONE with a=0x01,b=0x01 -> second done 9 cycles later, sum=0x02.
//   5. rst asserted at cycle 4 of 0x80+0x80 -> immediately busy=0,done=0,sum=0,cout=0; no done pulse afterward.
//   6. SERIAL_ADD_OVF_EN: 0x7F+0x01 -> sum=0x80,ovf=1,cout=0; 0xFF+0x01 -> ovf=0,cout=1.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial adder sequencer: FSM state encoding and default width.
package serial_add_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Shared 1-bit adder slice: two half-adder cells plus an OR for the carry.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0, c0, c1;

    half_adder ha0 (.x(a),  .y(b),   .s(s0), .c(c0));
    half_adder ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one full-adder slice, LSB first, one bit per clock.
// Optional macro SERIAL_ADD_OVF_EN adds a signed-overflow output held alongside cout.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic             carry;
    logic             fa_s, fa_c;
    logic             last, accept;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = start && (state == S_IDLE || state == S_DONE);

    full_adder_1b u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (fa_s),
        .cout(fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // The final sum bit lands in sum_sr on the same edge the result registers
    // load, so the result is taken from the shift input rather than sum_sr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
            carry  <= fa_c;
            cnt    <= cnt + CW'(1);
            if (last) begin
                sum  <= {fa_s, sum_sr[WIDTH-1:1]};
                cout <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                // carry reg still holds the carry into the MSB here
                ovf  <= carry ^ fa_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed scoreboard bench for serial_add_ctrl at WIDTH=8; define SERIAL_ADD_OVF_EN to cover ovf.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk, rst, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf  (ovf),
`endif
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a start at the current negedge; the following posedge accepts it.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input bit push);
        exp_t       e;
        logic [W:0] full;
        logic [W-1:0] low;
        a = ia; b = ib; cin = ic; start = 1'b1;
        full = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
        low  = {1'b0, ia[W-2:0]} + {1'b0, ib[W-2:0]} + {{(W-1){1'b0}}, ic};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = low[W-1] ^ full[W];
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    // idx0 = interval number (1 = just after the accepting edge) at call time.
    // Returns at the negedge where done is observed.
    task automatic wait_done(input int idx0);
        exp_t e;
        for (int i = idx0; i <= W + 1; i++) begin
            if (i > idx0) @(negedge clk);
            if (i <= W) begin
                chk("busy_run", 32'(busy), 32'd1);
                chk("done_early", 32'(done), 32'd0);
            end else begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_done", 32'(busy), 32'd0);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
                    chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
        end
    endtask

    task automatic check_pulse_end();
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_not_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        // 1. zero operands
        @(negedge clk); issue(8'h00, 8'h00, 1'b0, 1); wait_done(1); check_pulse_end();
        // 2. carry-propagating cases
        @(negedge clk); issue(8'hFF, 8'h01, 1'b0, 1); wait_done(1); check_pulse_end();
        @(negedge clk); issue(8'h5A, 8'hA5, 1'b1, 1); wait_done(1); check_pulse_end();
        chk("sum_held", 32'(sum), 32'h00);
        chk("cout_held", 32'(cout), 32'd1);

        // 3. start re-pulsed while busy is ignored
        @(negedge clk); issue(8'h3C, 8'h12, 1'b0, 1);
        @(negedge clk);
        @(negedge clk); start = 1'b1; a = 8'hFF;
        @(negedge clk); start = 1'b0;
        wait_done(4); check_pulse_end();

        // 4. back-to-back: start asserted in DONE
        @(negedge clk); issue(8'h01, 8'h01, 1'b0, 1); wait_done(1);
        issue(8'h01, 8'h01, 1'b0, 1); wait_done(1); check_pulse_end();

        // 6. signed overflow cases (ovf checked only when the port exists)
        @(negedge clk); issue(8'h7F, 8'h01, 1'b0, 1); wait_done(1); check_pulse_end();
        @(negedge clk); issue(8'hFF, 8'h01, 1'b0, 1); wait_done(1); check_pulse_end();
        @(negedge clk); issue(8'h80, 8'h80, 1'b0, 1); wait_done(1); check_pulse_end();

        for (int k = 0; k < 4; k++) begin
            @(negedge clk); issue(W'($urandom), W'($urandom), 1'($urandom), 1);
            wait_done(1); check_pulse_end();
        end

        // 5. reset mid-run abandons the operation
        @(negedge clk); issue(8'h80, 8'h80, 1'b0, 0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        chk("post_rst_sum", 32'(sum), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
